// File: rtl/trans_flow_ctrl.sv
// Transaction-layer flow control: sequences the VC/D FIFO datapath, latches the
// almost-full thresholds, arbitrates VC0/VC1 heads into D0/D1 and drives Pausa_MF.
module trans_flow_ctrl #(
  parameter int         DW      = 6,
  parameter logic [1:0] UMF_RST = 2'd3,
  parameter logic [1:0] UD_RST  = 2'd3,
  parameter logic [3:0] UVC_RST = 4'd12
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [1:0]    umbral_mf_in,
  input  logic [1:0]    umbral_d0_in,
  input  logic [1:0]    umbral_d1_in,
  input  logic [3:0]    umbral_vc0_in,
  input  logic [3:0]    umbral_vc1_in,
  output logic [1:0]    umbral_mf,
  output logic [1:0]    umbral_d0,
  output logic [1:0]    umbral_d1,
  output logic [3:0]    umbral_vc0,
  output logic [3:0]    umbral_vc1,
  input  logic [4:0]    empty_vec,
  input  logic [4:0]    afull_vec,
  input  logic [4:0]    fifo_err,
  input  logic [DW-1:0] vc0_head,
  input  logic [DW-1:0] vc1_head,
  output logic          pop_vc0,
  output logic          pop_vc1,
  output logic          push_d0,
  output logic          push_d1,
  output logic [DW-1:0] data_d,
  output logic          Pausa_MF,
  output logic          idle_out,
  output logic          active_out,
  output logic          error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    umbral_mf_q, umbral_mf_d;
  logic [1:0]    umbral_d0_q, umbral_d0_d;
  logic [1:0]    umbral_d1_q, umbral_d1_d;
  logic [3:0]    umbral_vc0_q, umbral_vc0_d;
  logic [3:0]    umbral_vc1_q, umbral_vc1_d;
  logic [DW-1:0] data_q;
  logic          pausa_q, pausa_d;
  logic          vc0_ok, vc1_ok;

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  // Next-state logic; the error escape outranks init and the idle/active moves
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (|fifo_err)             state_d = ST_ERROR;
        else if (init)             state_d = ST_INIT;
        else if (empty_vec != 5'h1F) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|fifo_err)             state_d = ST_ERROR;
        else if (init)             state_d = ST_INIT;
        else if (empty_vec == 5'h1F) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // A VC head is eligible when its FIFO has data and its target D FIFO has room
  assign vc0_ok = !empty_vec[3] && !(vc0_head[DW-2] ? afull_vec[0] : afull_vec[1]);
  assign vc1_ok = !empty_vec[2] && !(vc1_head[DW-2] ? afull_vec[0] : afull_vec[1]);

  // Output logic: status decode and strict-priority arbiter
  always_comb begin
    pop_vc0    = 1'b0;
    pop_vc1    = 1'b0;
    push_d0    = 1'b0;
    push_d1    = 1'b0;
    data_d     = data_q;
    idle_out   = (state_q == ST_IDLE);
    active_out = (state_q == ST_ACTIVE);
    error_out  = (state_q == ST_ERROR);
    if (state_q == ST_ACTIVE) begin
      if (vc0_ok) begin
        pop_vc0 = 1'b1;
        push_d0 = !vc0_head[DW-2];
        push_d1 = vc0_head[DW-2];
        data_d  = vc0_head;
      end else if (vc1_ok) begin
        pop_vc1 = 1'b1;
        push_d0 = !vc1_head[DW-2];
        push_d1 = vc1_head[DW-2];
        data_d  = vc1_head;
      end
    end
  end

  // Thresholds track their inputs only while initialising
  always_comb begin
    umbral_mf_d  = umbral_mf_q;
    umbral_d0_d  = umbral_d0_q;
    umbral_d1_d  = umbral_d1_q;
    umbral_vc0_d = umbral_vc0_q;
    umbral_vc1_d = umbral_vc1_q;
    if (state_q == ST_INIT) begin
      umbral_mf_d  = umbral_mf_in;
      umbral_d0_d  = umbral_d0_in;
      umbral_d1_d  = umbral_d1_in;
      umbral_vc0_d = umbral_vc0_in;
      umbral_vc1_d = umbral_vc1_in;
    end
  end

  // Back-pressure follows the state being entered so ERROR asserts it on entry
  always_comb begin
    case (state_d)
      ST_ERROR:         pausa_d = 1'b1;
      ST_RESET, ST_INIT: pausa_d = 1'b0;
      default:          pausa_d = |(afull_vec & 5'h0F);
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      umbral_mf_q  <= UMF_RST;
      umbral_d0_q  <= UD_RST;
      umbral_d1_q  <= UD_RST;
      umbral_vc0_q <= UVC_RST;
      umbral_vc1_q <= UVC_RST;
      data_q       <= '0;
      pausa_q      <= 1'b0;
    end else begin
      umbral_mf_q  <= umbral_mf_d;
      umbral_d0_q  <= umbral_d0_d;
      umbral_d1_q  <= umbral_d1_d;
      umbral_vc0_q <= umbral_vc0_d;
      umbral_vc1_q <= umbral_vc1_d;
      data_q       <= data_d;
      pausa_q      <= pausa_d;
    end
  end

  assign umbral_mf  = umbral_mf_q;
  assign umbral_d0  = umbral_d0_q;
  assign umbral_d1  = umbral_d1_q;
  assign umbral_vc0 = umbral_vc0_q;
  assign umbral_vc1 = umbral_vc1_q;
  assign Pausa_MF   = pausa_q;

endmodule

// File: tb/tb_trans_flow_ctrl.sv
// Bench for trans_flow_ctrl: directed vectors, transfers checked by a scoreboard
// monitor, status/threshold values checked inline.
module tb_trans_flow_ctrl;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset_L, init;
  logic [1:0]    umbral_mf_in, umbral_d0_in, umbral_d1_in;
  logic [3:0]    umbral_vc0_in, umbral_vc1_in;
  logic [1:0]    umbral_mf, umbral_d0, umbral_d1;
  logic [3:0]    umbral_vc0, umbral_vc1;
  logic [4:0]    empty_vec, afull_vec, fifo_err;
  logic [DW-1:0] vc0_head, vc1_head, data_d;
  logic          pop_vc0, pop_vc1, push_d0, push_d1;
  logic          Pausa_MF, idle_out, active_out, error_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  trans_flow_ctrl #(.DW(DW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_mf_in(umbral_mf_in), .umbral_d0_in(umbral_d0_in), .umbral_d1_in(umbral_d1_in),
    .umbral_vc0_in(umbral_vc0_in), .umbral_vc1_in(umbral_vc1_in),
    .umbral_mf(umbral_mf), .umbral_d0(umbral_d0), .umbral_d1(umbral_d1),
    .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1),
    .empty_vec(empty_vec), .afull_vec(afull_vec), .fifo_err(fifo_err),
    .vc0_head(vc0_head), .vc1_head(vc1_head),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_d(data_d), .Pausa_MF(Pausa_MF),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe cycle must match the oldest expected transfer
  always @(negedge clk) begin
    if (pop_vc0 | pop_vc1 | push_d0 | push_d1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL xfer_unexpected: got %0h expected none",
                 {pop_vc0, pop_vc1, push_d0, push_d1, data_d});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({pop_vc0, pop_vc1, push_d0, push_d1, data_d} !== e) begin
          n_bad++;
          $display("FAIL xfer: got %0h expected %0h",
                   {pop_vc0, pop_vc1, push_d0, push_d1, data_d}, e);
        end else begin
          $display("ok   xfer: %0h", e);
        end
      end
    end
  end

  initial begin
    reset_L = 1'b0; init = 1'b0;
    umbral_mf_in = 2'd0; umbral_d0_in = 2'd0; umbral_d1_in = 2'd0;
    umbral_vc0_in = 4'd0; umbral_vc1_in = 4'd0;
    empty_vec = 5'h1F; afull_vec = 5'h00; fifo_err = 5'h00;
    vc0_head = '0; vc1_head = '0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_status", {idle_out, active_out, error_out, Pausa_MF}, 4'b0000);
    chk("rst_strobes", {pop_vc0, pop_vc1, push_d0, push_d1}, 4'b0000);
    chk("rst_data", data_d, 6'h00);
    chk("rst_umbral_vc0", umbral_vc0, 4'd12);
    chk("rst_umbral_mf_d1", {umbral_mf, umbral_d1}, 4'b1111);

    // 2: threshold load during INIT
    step();
    reset_L = 1'b1; init = 1'b1;
    umbral_vc0_in = 4'd5; umbral_d1_in = 2'd1;
    umbral_mf_in = 2'd2; umbral_d0_in = 2'd2; umbral_vc1_in = 4'd9;
    step();                       // RESET -> INIT
    step();                       // INIT loads, stays in INIT
    chk("init_umbral_vc0", umbral_vc0, 4'd5);
    chk("init_not_idle", idle_out, 1'b0);
    init = 1'b0;
    step();                       // INIT -> IDLE
    chk("idle_out", {idle_out, active_out, error_out}, 3'b100);
    umbral_vc0_in = 4'd15; umbral_d1_in = 2'd0; umbral_vc1_in = 4'd0;
    step(); step();
    chk("held_umbrals", {umbral_vc0, umbral_d1, umbral_vc1, umbral_mf, umbral_d0},
        {4'd5, 2'd1, 4'd9, 2'd2, 2'd2});

    // 3: single VC0 transfer to D1
    empty_vec = 5'b01111;
    step();                       // IDLE -> ACTIVE
    chk("active_out", {idle_out, active_out}, 2'b01);
    vc0_head = 6'b011011; empty_vec = 5'b00111;
    exp_q.push_back({4'b1001, 6'h1B});
    step();

    // 4: arbitration cases
    vc0_head = 6'b001010; vc1_head = 6'b111011;
    afull_vec = 5'b00010; empty_vec = 5'b00011;
    exp_q.push_back({4'b0101, 6'h3B});  // VC0 blocked by afull_d0, VC1 -> D1
    step();
    afull_vec = 5'b00000;
    exp_q.push_back({4'b1010, 6'h0A});  // both eligible, VC0 wins -> D0
    chk("pausa_from_afull_d0", Pausa_MF, 1'b1);
    step();
    chk("pausa_clear", Pausa_MF, 1'b0);
    vc0_head = 6'b010101; vc1_head = 6'b100111; afull_vec = 5'b00001;
    exp_q.push_back({4'b0110, 6'h27});  // VC0 blocked by afull_d1, VC1 -> D0
    step();
    afull_vec = 5'b00000; empty_vec = 5'b01111;
    #1;
    chk("idle_arb_hold", {pop_vc0, pop_vc1, push_d0, push_d1, data_d}, {4'b0000, 6'h27});
    step();

    // 5: Pausa_MF follows afull_vc1 with one cycle delay
    chk("pausa_base", Pausa_MF, 1'b0);
    afull_vec = 5'b00100;
    #1;
    chk("pausa_not_yet", Pausa_MF, 1'b0);
    step();
    chk("pausa_set", Pausa_MF, 1'b1);
    afull_vec = 5'b00000;
    #1;
    chk("pausa_still", Pausa_MF, 1'b1);
    step();
    chk("pausa_drop", Pausa_MF, 1'b0);

    // 6: error with simultaneous init, sticky
    fifo_err = 5'b01000; init = 1'b1;
    step();
    chk("err_entry", {idle_out, active_out, error_out, Pausa_MF}, 4'b0011);
    fifo_err = 5'b00000; init = 1'b0;
    empty_vec = 5'b00111; vc0_head = 6'b011011;
    #1;
    chk("err_strobes", {pop_vc0, pop_vc1, push_d0, push_d1}, 4'b0000);
    repeat (3) step();
    chk("err_sticky", {error_out, Pausa_MF}, 2'b11);
    reset_L = 1'b0;
    #1;
    chk("err_reset", {idle_out, active_out, error_out, Pausa_MF}, 4'b0000);
    chk("err_reset_umbral", umbral_vc0, 4'd12);

    // Reset dropped mid-transfer suppresses the strobes at once
    empty_vec = 5'h1F;
    step();
    reset_L = 1'b1; init = 1'b1;
    step();                       // -> INIT
    init = 1'b0;
    step();                       // -> IDLE
    empty_vec = 5'b01111;
    step();                       // -> ACTIVE
    chk("re_active", active_out, 1'b1);
    empty_vec = 5'b00111; vc0_head = 6'b011011;
    #2;
    reset_L = 1'b0;
    #1;
    chk("abort_strobes", {pop_vc0, pop_vc1, push_d0, push_d1, data_d}, 10'd0);
    step(); step();

    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
